// File: rtl/board_clear_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_clear_pkg
// Description : Shared geometry, cell indexing and FSM encoding for the
//               playfield store.
// Revision    : 1.0 - initial release
// ============================================================================
package board_clear_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 20;
    localparam int CELL_W   = 3;
    localparam int NCELLS   = BOARD_W * BOARD_H;
    localparam int TOP_ROWS = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_WIPE  = 3'd4
    } state_t;

    // Linear cell index, identical to the display address row*10+col.
    function automatic logic [7:0] cell_idx(input logic [4:0] row, input logic [3:0] col);
        return 8'(row) * 8'(BOARD_W) + 8'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_row_full.sv
`default_nettype none
// ============================================================================
// Module      : board_row_full
// Description : Combinational test that every cell of one row is occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module board_row_full
    import board_clear_pkg::*;
#(
    parameter int BOARD_W = board_clear_pkg::BOARD_W
) (
    input  logic [BOARD_W*CELL_W-1:0] i_row,
    output logic                      o_full
);

    logic [BOARD_W-1:0] w_occ;

    for (genvar c = 0; c < BOARD_W; c++) begin : g_cell
        assign w_occ[c] = |i_row[c*CELL_W +: CELL_W];
    end

    assign o_full = &w_occ;

endmodule
`default_nettype wire

// File: rtl/board_clear.sv
`default_nettype none
// ============================================================================
// Module      : board_clear
// Description : Playfield store with piece lock, line clear and wipe FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module board_clear
    import board_clear_pkg::*;
#(
    parameter int BOARD_W  = board_clear_pkg::BOARD_W,
    parameter int BOARD_H  = board_clear_pkg::BOARD_H,
    parameter int TOP_ROWS = board_clear_pkg::TOP_ROWS
) (
    input  logic       pclk,
    input  logic       rstn,
    input  logic [7:0] raddr,
    output logic [2:0] rdata,
    input  logic       lock,
    input  logic [4:0] lx1,
    input  logic [4:0] lx2,
    input  logic [4:0] lx3,
    input  logic [4:0] lx4,
    input  logic [4:0] ly1,
    input  logic [4:0] ly2,
    input  logic [4:0] ly3,
    input  logic [4:0] ly4,
    input  logic [2:0] ltype,
    input  logic       wipe,
    output logic       busy,
    output logic       done,
    output logic [2:0] lines,
    output logic       fail
);

    localparam int         c_ROW_BITS = BOARD_W * CELL_W;
    localparam logic [4:0] c_W        = 5'(BOARD_W);
    localparam logic [4:0] c_H        = 5'(BOARD_H);
    localparam logic [4:0] c_LAST_ROW = 5'(BOARD_H - 1);

    // Whole board as one flat vector; row r occupies bits [r*30 +: 30].
    logic [NCELLS*CELL_W-1:0] r_board;
    state_t                   r_state;
    logic [4:0]               r_r;
    logic [4:0]               r_k;
    logic [2:0]               r_lines;
    logic                     r_fail;

    logic [c_ROW_BITS-1:0]    w_row;
    logic                     w_full;
    logic                     w_top_occ;
    logic [3:0][4:0]          w_lx;
    logic [3:0][4:0]          w_ly;

    assign w_lx      = {lx4, lx3, lx2, lx1};
    assign w_ly      = {ly4, ly3, ly2, ly1};
    assign w_row     = r_board[c_ROW_BITS*int'(r_r) +: c_ROW_BITS];
    assign w_top_occ = |r_board[TOP_ROWS*c_ROW_BITS-1:0];

    board_row_full #(
        .BOARD_W (BOARD_W)
    ) u_row_full (
        .i_row  (w_row),
        .o_full (w_full)
    );

    assign rdata = (raddr < 8'(NCELLS)) ? r_board[CELL_W*int'(raddr) +: CELL_W] : '0;
    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign lines = r_lines;
    assign fail  = r_fail;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_board <= '0;
            r_state <= ST_IDLE;
            r_r     <= '0;
            r_k     <= '0;
            r_lines <= '0;
            r_fail  <= 1'b0;
        end else if (wipe) begin
            // Wipe pre-empts everything, including a lock in the same cycle.
            r_state <= ST_WIPE;
            r_k     <= '0;
            r_lines <= '0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lock) begin
                        for (int p = 0; p < 4; p++) begin
                            if (w_lx[p] < c_W && w_ly[p] < c_H) begin
                                r_board[CELL_W*int'(cell_idx(w_ly[p], w_lx[p][3:0])) +: CELL_W] <= ltype;
                            end
                        end
                        r_r     <= c_LAST_ROW;
                        r_lines <= '0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_full) begin
                        r_k     <= r_r;
                        r_lines <= r_lines + 3'd1;
                        r_state <= ST_SHIFT;
                    end else if (r_r == 5'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_r <= r_r - 5'd1;
                    end
                end
                ST_SHIFT: begin
                    // Row r is re-checked afterwards since the row above fell into it.
                    if (r_k == 5'd0) begin
                        r_board[c_ROW_BITS-1:0] <= '0;
                        r_state                 <= ST_CHECK;
                    end else begin
                        r_board[c_ROW_BITS*int'(r_k) +: c_ROW_BITS] <=
                            r_board[c_ROW_BITS*int'(r_k - 5'd1) +: c_ROW_BITS];
                        r_k <= r_k - 5'd1;
                    end
                end
                ST_DONE: begin
                    r_fail  <= r_fail | w_top_occ;
                    r_state <= ST_IDLE;
                end
                ST_WIPE: begin
                    r_board[c_ROW_BITS*int'(r_k) +: c_ROW_BITS] <= '0;
                    if (r_k == c_LAST_ROW) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_k <= r_k + 5'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_clear.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_clear
// Description : Self-checking bench for board_clear (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_clear;

    logic       pclk  = 1'b0;
    logic       rstn  = 1'b0;
    logic [7:0] raddr = '0;
    logic [2:0] rdata;
    logic       lock  = 1'b0;
    logic [4:0] lx1 = '0, lx2 = '0, lx3 = '0, lx4 = '0;
    logic [4:0] ly1 = '0, ly2 = '0, ly3 = '0, ly4 = '0;
    logic [2:0] ltype = '0;
    logic       wipe  = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] lines;
    logic       fail;

    always #5 pclk = ~pclk;

    board_clear dut (
        .pclk  (pclk),
        .rstn  (rstn),
        .raddr (raddr),
        .rdata (rdata),
        .lock  (lock),
        .lx1   (lx1),
        .lx2   (lx2),
        .lx3   (lx3),
        .lx4   (lx4),
        .ly1   (ly1),
        .ly2   (ly2),
        .ly3   (ly3),
        .ly4   (ly4),
        .ltype (ltype),
        .wipe  (wipe),
        .busy  (busy),
        .done  (done),
        .lines (lines),
        .fail  (fail)
    );

    typedef logic [3:0][4:0] coord_t;
    typedef struct packed {
        coord_t     x;
        coord_t     y;
        logic [2:0] t;
        logic [2:0] lines;
        logic [7:0] busy;
        logic       fail;
    } vec_t;
    typedef struct packed {
        logic [2:0] lines;
        logic [7:0] busy;
        logic       fail;
    } exp_t;

    exp_t       sb[$];
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         done_cnt  = 0;
    int         busy_cnt  = 0;
    logic       fail_pend = 1'b0;
    logic       fail_exp  = 1'b0;
    logic [2:0] model [200];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3,
                                input int y0, input int y1, input int y2, input int y3,
                                input int t, input int ln, input int bz, input int fl);
        vec_t v;
        v.x     = {5'(x3), 5'(x2), 5'(x1), 5'(x0)};
        v.y     = {5'(y3), 5'(y2), 5'(y1), 5'(y0)};
        v.t     = 3'(t);
        v.lines = 3'(ln);
        v.busy  = 8'(bz);
        v.fail  = 1'(fl);
        return v;
    endfunction

    // Reference model: write in-range cells, then compact away full rows.
    task automatic model_clear();
        for (int i = 0; i < 200; i++) model[i] = '0;
    endtask

    task automatic model_lock(input vec_t v);
        logic [2:0] nb [200];
        int         dst;
        bit         full;
        for (int p = 0; p < 4; p++)
            if (int'(v.x[p]) < 10 && int'(v.y[p]) < 20)
                model[int'(v.y[p]) * 10 + int'(v.x[p])] = v.t;
        for (int i = 0; i < 200; i++) nb[i] = '0;
        dst = 19;
        for (int r = 19; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (model[r*10+c] == 3'd0) full = 1'b0;
            if (!full) begin
                for (int c = 0; c < 10; c++) nb[dst*10+c] = model[r*10+c];
                dst--;
            end
        end
        for (int i = 0; i < 200; i++) model[i] = nb[i];
    endtask

    task automatic check_board(input string name);
        int         bad;
        int         first;
        logic [2:0] e;
        bad   = 0;
        first = -1;
        for (int a = 0; a < 256; a++) begin
            raddr = 8'(a);
            #1;
            e = (a < 200) ? model[a] : 3'd0;
            if (rdata !== e) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        if (bad != 0) $display("  %s: first bad cell at raddr %0d", name, first);
        chk(name, bad, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge pclk);
            n++;
        end
        chk("idle_timeout_busy", int'(busy), 0);
    endtask

    task automatic drive_coords(input vec_t v);
        {lx4, lx3, lx2, lx1} = v.x;
        {ly4, ly3, ly2, ly1} = v.y;
        ltype = v.t;
    endtask

    task automatic do_lock(input vec_t v, input bit push, input bit wt);
        @(negedge pclk);
        drive_coords(v);
        lock = 1'b1;
        if (push) sb.push_back(exp_t'{lines: v.lines, busy: v.busy, fail: v.fail});
        @(negedge pclk);
        lock = 1'b0;
        if (wt) wait_idle();
    endtask

    task automatic do_wipe(input string tag);
        int n;
        @(negedge pclk);
        wipe = 1'b1;
        @(negedge pclk);
        wipe = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge pclk);
        end
        chk({tag, "_wipe_busy_cycles"}, n, 20);
        chk({tag, "_wipe_fail"}, int'(fail), 0);
        chk({tag, "_wipe_lines"}, int'(lines), 0);
        model_clear();
        check_board({tag, "_wipe_board"});
    endtask

    // Scoreboard consumer: every done pulse pops one expected lock result.
    always @(negedge pclk) begin
        exp_t e;
        if (!rstn) begin
            busy_cnt  = 0;
            fail_pend = 1'b0;
        end else begin
            if (fail_pend) begin
                chk("fail_after_done", int'(fail), int'(fail_exp));
                fail_pend = 1'b0;
            end
            if (busy) busy_cnt++;
            else      busy_cnt = 0;
            if (done) begin
                done_cnt++;
                chk("sb_pending_on_done", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("lines_at_done", int'(lines), int'(e.lines));
                    chk("busy_cycles_at_done", busy_cnt, int'(e.busy));
                    fail_exp  = e.fail;
                    fail_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        int   dc0;

        tbl[0]  = mk(0, 1, 2, 3, 19, 19, 19, 19, 1, 0, 21, 0);
        tbl[1]  = mk(4, 5, 6, 7, 19, 19, 19, 19, 1, 0, 21, 0);
        tbl[2]  = mk(8, 9, 9, 9, 19, 19, 18, 18, 1, 1, 42, 0);
        for (int c = 1; c <= 9; c++)
            tbl[2+c] = mk(c, c, c, c, 16, 17, 18, 19, (c % 7) + 1, 0, 21, 0);
        tbl[12] = mk(0, 0, 0, 0, 16, 17, 18, 19, 2, 4, 105, 0);
        tbl[13] = mk(4, 4, 4, 4, 2, 3, 4, 5, 3, 0, 21, 1);
        tbl[14] = mk(0, 1, 2, 3, 19, 19, 19, 19, 4, 0, 21, 1);
        tbl[15] = mk(10, 3, 31, 2, 5, 20, 31, 5, 7, 0, 21, 1);

        model_clear();
        repeat (3) @(negedge pclk);
        chk("reset_busy",  int'(busy),  0);
        chk("reset_done",  int'(done),  0);
        chk("reset_lines", int'(lines), 0);
        chk("reset_fail",  int'(fail),  0);
        rstn = 1'b1;
        check_board("reset_board");

        for (int i = 0; i < 16; i++) begin
            do_lock(tbl[i], 1'b1, 1'b1);
            model_lock(tbl[i]);
            check_board($sformatf("board_after_vec%0d", i));
        end
        chk("fail_sticky_before_wipe", int'(fail), 1);

        do_wipe("idle");

        // Wipe while a line clear is shifting.
        do_lock(mk(0, 1, 2, 3, 19, 19, 19, 0, 5, 0, 21, 1), 1'b1, 1'b1);
        model_lock(mk(0, 1, 2, 3, 19, 19, 19, 0, 5, 0, 21, 1));
        do_lock(mk(3, 4, 5, 6, 19, 19, 19, 19, 5, 0, 21, 1), 1'b1, 1'b1);
        @(negedge pclk);
        chk("fail_before_abort", int'(fail), 1);
        do_lock(mk(7, 8, 9, 9, 19, 19, 19, 18, 5, 0, 0, 0), 1'b0, 1'b0);
        repeat (3) @(negedge pclk);
        chk("busy_in_shift", int'(busy), 1);
        dc0 = done_cnt;
        do_wipe("shift");
        repeat (5) @(negedge pclk);
        chk("no_done_after_abort", done_cnt, dc0);

        // Lock pulsed five cycles into a running sequence is ignored.
        dc0 = done_cnt;
        do_lock(mk(0, 1, 2, 3, 19, 19, 19, 19, 6, 0, 21, 0), 1'b1, 1'b0);
        model_lock(mk(0, 1, 2, 3, 19, 19, 19, 19, 6, 0, 21, 0));
        repeat (3) @(negedge pclk);
        do_lock(mk(5, 6, 7, 8, 10, 10, 10, 10, 7, 0, 0, 0), 1'b0, 1'b1);
        repeat (3) @(negedge pclk);
        chk("single_done_pulse", done_cnt, dc0 + 1);
        check_board("board_after_ignored_lock");

        // Asynchronous reset mid-sequence, then a lock on the first edge after release.
        do_lock(mk(0, 1, 2, 3, 0, 0, 0, 0, 1, 0, 21, 1), 1'b1, 1'b1);
        model_lock(mk(0, 1, 2, 3, 0, 0, 0, 0, 1, 0, 21, 1));
        @(negedge pclk);
        do_lock(mk(4, 5, 6, 7, 19, 19, 19, 19, 2, 0, 0, 0), 1'b0, 1'b0);
        repeat (2) @(negedge pclk);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_fail", int'(fail), 0);
        chk("async_reset_done", int'(done), 0);
        model_clear();
        check_board("board_after_async_reset");
        @(negedge pclk);
        rstn = 1'b1;
        drive_coords(mk(5, 5, 5, 5, 16, 17, 18, 19, 2, 0, 21, 0));
        lock = 1'b1;
        sb.push_back(exp_t'{lines: 3'd0, busy: 8'd21, fail: 1'b0});
        @(negedge pclk);
        lock = 1'b0;
        wait_idle();
        model_lock(mk(5, 5, 5, 5, 16, 17, 18, 19, 2, 0, 21, 0));
        repeat (2) @(negedge pclk);
        check_board("board_after_first_edge_lock");
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_clear.md
BOARD_CLEAR -- requirements
Module: board_clear

Interface
REQ-001 Parameter BOARD_W, 10, playfield columns.
REQ-002 Parameter BOARD_H, 20, playfield rows.
REQ-003 Parameter TOP_ROWS, 3, spawn-zone rows (0..TOP_ROWS-1) whose occupancy after a lock means game over.
REQ-004 pclk  in  1  pixel/system clock; all state on rising edge.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 raddr  in  8  display read address = row*10+col.
REQ-007 rdata  out  3  cell colour at raddr (0 empty, 1-7 piece type).
REQ-008 lock  in  1  one-cycle request to write the active piece into the board.
REQ-009 lx1..lx4, ly1..ly4  in  5 each  piece cell coordinates (x 0-9, y 0-19).
REQ-010 ltype  in  3  colour code written for all four cells.
REQ-011 wipe  in  1  one-cycle request to empty the board (new game).
REQ-012 busy  out  1  high while any lock/clear/wipe sequence runs.
REQ-013 done  out  1  one-cycle pulse at end of each lock sequence.
REQ-014 lines  out  3  rows cleared by the most recent lock (0-4), valid from done onward.
REQ-015 fail  out  1  sticky game-over flag.

Function
REQ-016 Storage is 200 cells x 3 bits; rdata is a combinational read of the current array, 0 when raddr>=200; the display samples it in the same cycle.
REQ-017 FSM states: IDLE, CHECK, SHIFT, DONE, WIPE; busy=1 in all states except IDLE; done=1 only in DONE.
REQ-018 IDLE + lock=1 (wipe=0): on that edge write ltype to each in-range cell (x<=9, y<=19); out-of-range cells are dropped silently; duplicate coordinates are harmless; set r=19, lines=0, go CHECK.
REQ-019 CHECK (one cycle): row r full (all 10 cells nonzero) -> go SHIFT with k=r, lines+1; else r=0 -> DONE, else r-1, stay CHECK.
REQ-020 SHIFT: one row per cycle, row k <= row k-1, k decrements; at k=0, row 0 <= 0 and return to CHECK with the same r; a shift of row r costs r+1 cycles.
REQ-021 DONE (one cycle): done=1; fail <= fail OR any nonzero cell in rows 0..TOP_ROWS-1; then IDLE.
REQ-022 Lock with no full rows: busy high exactly 21 cycles (20 CHECK + DONE).
REQ-023 lock asserted while busy=1 is ignored, with no buffering.
REQ-024 wipe in any state (including mid-CHECK/SHIFT): go WIPE; WIPE zeroes one row per cycle, row 0..19 (20 cycles), then IDLE; fail <= 0, lines <= 0; no done pulse for an aborted lock.
REQ-025 wipe and lock in the same IDLE cycle: wipe wins, lock is dropped.
REQ-026 lines saturates by construction at 4; it holds its value until the next accepted lock or wipe.

Reset
REQ-027 rstn low: all 200 cells 0, state IDLE, busy 0, done 0, lines 0, fail 0, row/shift counters 0; takes effect immediately and asynchronously, aborting any sequence.
REQ-028 After rstn deasserts, a lock is accepted on the first rising edge.

Structure
REQ-029 The shared package holds BOARD_W, BOARD_H, CELL_W=3, NCELLS=200, TOP_ROWS, and the FSM state encoding.
REQ-030 The combinational 10-cell row-full test lives in the sub-module board_row_full, which takes one row and returns full.
REQ-031 The block is intended as the board store feeding the display's rdata1/rdata2 read port; one instance is used per player.

Verification
REQ-032 Reset, then read raddr 0..199 -> every rdata=0; raddr 200..255 -> rdata=0; busy=0, fail=0.
REQ-033 Three locks with ltype=1: (0-3,19); (4-7,19); (8,19),(9,19),(9,18),(9,18) -> third lock: busy 42 cycles, lines=1, afterwards row 19 holds only col 9=1, row 18 is all 0.
REQ-034 Fill rows 16-19 minus col 0, then lock ltype=2 at (0,16..19) -> lines=4, all 200 cells 0, done pulses once.
REQ-035 Lock ltype=3 at (4,2),(4,3),(4,4),(4,5) on an empty board -> done pulse, fail=1, lines=0; fail stays 1 through subsequent locks until wipe.
REQ-036 Assert wipe during SHIFT -> no done pulse; busy holds 20 more cycles; all cells 0, fail=0.
REQ-037 Pulse lock 5 cycles after an accepted lock -> board unchanged by the second lock, exactly one done pulse.
